// File: rtl/vector_result_streamer.sv
// Captures a parallel result vector in one handshake and streams it out one element per beat.
// Optional running-sum output port out_sum enabled by defining VECTOR_RESULT_STREAMER_SUM_EN.
module vector_result_streamer #(
  parameter int VEC_LEN = 100,
  parameter int DATA_W  = 32,
  parameter int IDX_W   = $clog2(VEC_LEN),
  parameter int SUM_W   = DATA_W + 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] in_vec [0:VEC_LEN-1],
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [DATA_W-1:0] out_data,
  output logic [IDX_W-1:0]         out_index,
  output logic                     out_last,
  output logic                     busy
`ifdef VECTOR_RESULT_STREAMER_SUM_EN
  ,
  output logic signed [SUM_W-1:0]  out_sum
`endif
);

  typedef enum logic {IDLE, STREAM} state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(VEC_LEN - 1);

  state_t                     state_q, state_d;
  logic [IDX_W-1:0]           idx_q, idx_d;
  logic signed [DATA_W-1:0]   vec_buf [0:VEC_LEN-1];
  logic                       capture;
  logic                       beat;
  logic                       is_last;

  assign capture = in_valid && in_ready;
  assign beat    = out_valid && out_ready;
  assign is_last = (idx_q == LAST_IDX);

  // NOTE: every output and next-state signal gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    out_data  = '0;
    out_last  = 1'b0;
    out_index = idx_q;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          state_d = STREAM;
          idx_d   = '0;
        end
      end
      STREAM: begin
        out_valid = 1'b1;
        busy      = 1'b1;
        out_data  = vec_buf[idx_q];
        out_last  = is_last;
        if (out_ready) begin
          if (is_last) begin
            idx_d   = '0;
            state_d = IDLE;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // NOTE: the buffer is reset to all zeros so it never exposes stale data; this costs a reset net on every word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < VEC_LEN; i++) vec_buf[i] <= '0;
    end else if (capture) begin
      for (int i = 0; i < VEC_LEN; i++) vec_buf[i] <= in_vec[i];
    end
  end

`ifdef VECTOR_RESULT_STREAMER_SUM_EN
  logic signed [SUM_W-1:0] sum_q;
  logic signed [SUM_W-1:0] data_ext;

  assign data_ext = {{(SUM_W-DATA_W){out_data[DATA_W-1]}}, out_data};
  // out_data is zero outside STREAM, so out_sum equals the held sum while idle.
  assign out_sum  = sum_q + data_ext;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_q <= '0;
    end else if (capture) begin
      sum_q <= '0;
    end else if (beat) begin
      sum_q <= sum_q + data_ext;
    end
  end
`endif

endmodule

// File: tb/tb_vector_result_streamer.sv
// Scoreboard bench for vector_result_streamer: a model queue of expected beats is filled on
// each modelled capture and drained by a monitor on every observed beat.
module tb_vector_result_streamer;

  localparam int VEC_LEN = 100;
  localparam int DATA_W  = 32;
  localparam int IDX_W   = $clog2(VEC_LEN);
  localparam int SUM_W   = DATA_W + 8;

  typedef struct packed {
    logic signed [DATA_W-1:0] data;
    logic [IDX_W-1:0]         index;
    logic                     last;
  } exp_t;

  logic                     clk = 1'b0;
  logic                     rst;
  logic                     in_valid;
  logic                     in_ready;
  logic signed [DATA_W-1:0] in_vec [0:VEC_LEN-1];
  logic                     out_valid;
  logic                     out_ready;
  logic signed [DATA_W-1:0] out_data;
  logic [IDX_W-1:0]         out_index;
  logic                     out_last;
  logic                     busy;
`ifdef VECTOR_RESULT_STREAMER_SUM_EN
  logic signed [SUM_W-1:0]  out_sum;
  logic signed [SUM_W-1:0]  exp_sum;
`endif

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   n_captures = 0;

  vector_result_streamer #(.VEC_LEN(VEC_LEN), .DATA_W(DATA_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_vec    (in_vec),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_index (out_index),
    .out_last  (out_last),
    .busy      (busy)
`ifdef VECTOR_RESULT_STREAMER_SUM_EN
    ,
    .out_sum   (out_sum)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor and reference model: an idle block accepts any offered vector; a streaming block
  // presents the queued elements in order and pops one per accepted beat.
  always @(negedge clk) begin
    if (rst) begin
      check("rst_in_ready", in_ready, 1'b1);
      check("rst_out_valid", out_valid, 1'b0);
      check("rst_busy", busy, 1'b0);
    end else begin
      int n;
      n = exp_q.size();
      check("in_ready", in_ready, n == 0);
      check("out_valid", out_valid, n != 0);
      check("busy", busy, n != 0);
      if (n != 0) begin
        exp_t e;
        e = exp_q[0];
        check("out_data", out_data, e.data);
        check("out_index", out_index, e.index);
        check("out_last", out_last, e.last);
`ifdef VECTOR_RESULT_STREAMER_SUM_EN
        check("out_sum", out_sum, exp_sum + SUM_W'(e.data));
`endif
        if (out_ready) begin
          void'(exp_q.pop_front());
`ifdef VECTOR_RESULT_STREAMER_SUM_EN
          exp_sum = exp_sum + SUM_W'(e.data);
`endif
        end
      end else if (in_valid) begin
        for (int i = 0; i < VEC_LEN; i++)
          exp_q.push_back('{data: in_vec[i], index: IDX_W'(i), last: (i == VEC_LEN - 1)});
        n_captures++;
`ifdef VECTOR_RESULT_STREAMER_SUM_EN
        exp_sum = '0;
`endif
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic capture_vec(input bit keep_valid);
    bit ok;
    ok = 0;
    in_valid = 1'b1;
    for (int n = 0; n < 50; n++) begin
      tick();
      if (busy === 1'b1) begin
        ok = 1;
        break;
      end
    end
    if (!ok) check("capture_timeout", 1'b0, 1'b1);
    if (!keep_valid) in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 0;
    for (int n = 0; n < 2000; n++) begin
      if (exp_q.size() == 0 && in_ready === 1'b1) begin
        ok = 1;
        break;
      end
      tick();
    end
    if (!ok) check("idle_timeout", 1'b0, 1'b1);
  endtask

  task automatic wait_index(input int idx);
    bit ok;
    ok = 0;
    for (int n = 0; n < 500; n++) begin
      if (out_valid === 1'b1 && out_index == IDX_W'(idx)) begin
        ok = 1;
        break;
      end
      tick();
    end
    if (!ok) check("index_timeout", 1'b0, 1'b1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"}, in_ready, 1'b1);
    check({tag, "_out_valid"}, out_valid, 1'b0);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_out_data"}, out_data, '0);
    check({tag, "_out_index"}, out_index, '0);
    check({tag, "_out_last"}, out_last, 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    for (int i = 0; i < VEC_LEN; i++) in_vec[i] = '0;
    #2;
    check_reset_outputs("por");
    #11 rst = 1'b0;

    // asynchronous reset pulse between edges while idle
    tick();
    #2 rst = 1'b1;
    #1 check_reset_outputs("pulse");
    @(posedge clk);
    #3 rst = 1'b0;

    // ramp vector, downstream always ready
    tick();
    for (int i = 0; i < VEC_LEN; i++) in_vec[i] = i * 3 - 50;
    out_ready = 1'b1;
    capture_vec(0);
    wait_idle();

    // backpressure at index 10
    for (int i = 0; i < VEC_LEN; i++) in_vec[i] = 1000 + i;
    capture_vec(0);
    wait_index(10);
    out_ready = 1'b0;
    repeat (5) tick();
    check("stall_data", out_data, 32'sd1010);
    check("stall_index", out_index, IDX_W'(10));
    out_ready = 1'b1;
    wait_idle();

    // in_valid held through streaming with a second vector of all -1, random backpressure
    begin
      int base;
      base = n_captures;
      for (int i = 0; i < VEC_LEN; i++) in_vec[i] = $urandom;
      capture_vec(1);
      for (int i = 0; i < VEC_LEN; i++) in_vec[i] = -1;
      for (int n = 0; n < 1000 && n_captures < base + 2; n++) begin
        out_ready = ($urandom_range(0, 3) != 0);
        tick();
      end
      in_valid = 1'b0;
      check("second_capture", n_captures, base + 2);
      out_ready = 1'b1;
      wait_idle();
    end

    // reset mid-stream at index 40, then a fresh vector of 7s
    for (int i = 0; i < VEC_LEN; i++) in_vec[i] = $urandom;
    capture_vec(0);
    wait_index(40);
    #2 rst = 1'b1;
    exp_q.delete();
    #1 check_reset_outputs("midrst");
    @(posedge clk);
    #3 rst = 1'b0;
    tick();
    for (int i = 0; i < VEC_LEN; i++) in_vec[i] = 7;
    capture_vec(0);
    wait_idle();

    // two random vectors with random downstream stalls
    repeat (2) begin
      for (int i = 0; i < VEC_LEN; i++) in_vec[i] = $urandom;
      capture_vec(0);
      for (int n = 0; n < 1000 && exp_q.size() != 0; n++) begin
        out_ready = ($urandom_range(0, 2) != 0);
        tick();
      end
      out_ready = 1'b1;
      wait_idle();
    end

`ifdef VECTOR_RESULT_STREAMER_SUM_EN
    // most negative element in every slot: the full sum must fit SUM_W exactly
    for (int i = 0; i < VEC_LEN; i++) in_vec[i] = 32'sh8000_0000;
    capture_vec(0);
    wait_index(VEC_LEN - 1);
    check("sum_min", out_sum, -40'sd214748364800);
    wait_idle();
`endif

    repeat (3) tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
